// File: rtl/t05_hdec_pkg.sv
// Shared types for the Huffman decoder: FSM states, h_element field layout and child extractors.
package t05_hdec_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    GET_BIT = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_e;

  localparam int H_W         = 71;
  localparam int MAXIDX_MSB  = 70;
  localparam int LEFT_MSB    = 63;
  localparam int RIGHT_MSB   = 54;
  localparam int CHILD_W     = 9;
  localparam int CHILD_VAL_W = 8;
  localparam int SUM_W       = 46;

  // Child descriptor: is_int=1 -> val is a node index, is_int=0 -> val is a char.
  typedef struct packed {
    logic                   is_int;
    logic [CHILD_VAL_W-1:0] val;
  } child_t;

  function automatic child_t left_child(input logic [H_W-1:0] h);
    return child_t'(h[LEFT_MSB -: CHILD_W]);
  endfunction

  function automatic child_t right_child(input logic [H_W-1:0] h);
    return child_t'(h[RIGHT_MSB -: CHILD_W]);
  endfunction

endpackage

// File: rtl/t05_huffman_decoder.sv
// Huffman tree walker: one input bit per tree edge, emits decoded chars over a ready/valid sink.
// Optional T05_HDEC_DEPTH_CHECK_EN adds a path-depth limit that flags cyclic/corrupt trees.
module t05_huffman_decoder
  import t05_hdec_pkg::*;
#(
  parameter int IDX_W     = 7,
  parameter int CHAR_W    = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_DEPTH = 127
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [IDX_W-1:0]  max_index,
  input  logic [CNT_W-1:0]  num_chars,
  output logic              node_req,
  output logic [IDX_W-1:0]  node_index,
  input  logic              node_valid,
  input  logic [H_W-1:0]    h_element,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              char_valid,
  output logic [CHAR_W-1:0] char_out,
  input  logic              char_ready,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  root_q, root_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CHAR_W-1:0] char_q, char_d;
  child_t            left_q, left_d;
  child_t            right_q, right_d;
  child_t            sel;
  logic              unused_fields;

`ifdef T05_HDEC_DEPTH_CHECK_EN
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 2);
  logic [DEPTH_W-1:0] depth_q, depth_d;
`else
  localparam int unused_max_depth = MAX_DEPTH;
`endif

  // Only the child fields steer the walk; max_idx and sum are carried for the encoder side.
  assign unused_fields = ^{h_element[MAXIDX_MSB:LEFT_MSB+1], h_element[SUM_W-1:0]};

  always_comb begin
    state_d = state_q;
    root_d  = root_q;
    cur_d   = cur_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    left_d  = left_q;
    right_d = right_q;
    sel     = bit_in ? right_q : left_q;
`ifdef T05_HDEC_DEPTH_CHECK_EN
    depth_d = depth_q;
`endif

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          root_d  = max_index;
          cur_d   = max_index;
          num_d   = num_chars;
          cnt_d   = '0;
          state_d = (num_chars == '0) ? DONE : FETCH;
`ifdef T05_HDEC_DEPTH_CHECK_EN
          depth_d = '0;
`endif
        end
      end
      FETCH: begin
        if (node_valid) begin
          left_d  = left_child(h_element);
          right_d = right_child(h_element);
          state_d = GET_BIT;
        end
      end
      GET_BIT: begin
        if (bit_valid) begin
`ifdef T05_HDEC_DEPTH_CHECK_EN
          depth_d = depth_q + 1'b1;
          if (int'(depth_q) >= MAX_DEPTH) begin
            state_d = ERROR;
          end else
`endif
          if (sel.is_int) begin
            if (sel.val > CHILD_VAL_W'(root_q)) begin
              state_d = ERROR;
            end else begin
              cur_d   = IDX_W'(sel.val);
              state_d = FETCH;
            end
          end else begin
            char_d  = CHAR_W'(sel.val);
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (char_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == num_q) begin
            state_d = DONE;
          end else begin
            cur_d   = root_q;
            state_d = FETCH;
`ifdef T05_HDEC_DEPTH_CHECK_EN
            depth_d = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      root_q  <= '0;
      cur_q   <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
`ifdef T05_HDEC_DEPTH_CHECK_EN
      depth_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      root_q  <= root_d;
      cur_q   <= cur_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
`ifdef T05_HDEC_DEPTH_CHECK_EN
      depth_q <= depth_d;
`endif
    end
  end

  // Node child registers are pure data; they are always written before GET_BIT reads them.
  always_ff @(posedge clk) begin
    left_q  <= left_d;
    right_q <= right_d;
  end

  assign node_req   = (state_q == FETCH);
  assign node_index = cur_q;
  assign bit_ready  = (state_q == GET_BIT);
  assign char_valid = (state_q == EMIT);
  assign char_out   = char_q;
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERROR);

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Bench for t05_huffman_decoder: tree-store responder, randomized handshakes, code-table reference model.
module tb_t05_huffman_decoder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  max_index = 7'd8;
  logic [15:0] num_chars = 16'd0;
  logic        node_req;
  logic [6:0]  node_index;
  logic        node_valid = 1'b0;
  logic [70:0] h_element = '0;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_ready;
  logic        char_valid;
  logic [7:0]  char_out;
  logic        char_ready = 1'b0;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [70:0] tree [0:127];
  logic [31:0] code_path [0:255];
  int          code_len [0:255];
  bit          stim_bits [$];
  logic [7:0]  exp_chars [$];
  logic [6:0]  exp_fetch [$];
  logic [6:0]  fetch_log [$];
  bit          exp_err;
  int unsigned rsp_wait = 0;

  t05_huffman_decoder dut (
    .clk(clk), .nrst(nrst), .start(start), .max_index(max_index), .num_chars(num_chars),
    .node_req(node_req), .node_index(node_index), .node_valid(node_valid), .h_element(h_element),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .char_valid(char_valid), .char_out(char_out), .char_ready(char_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Tree store: answers each request after 0..2 extra cycles, logs the index served.
  always @(negedge clk) begin
    if (!nrst) begin
      node_valid = 1'b0;
    end else if (node_valid) begin
      node_valid = 1'b0;
    end else if (node_req) begin
      if (rsp_wait == 0) begin
        node_valid = 1'b1;
        h_element  = tree[node_index];
        fetch_log.push_back(node_index);
        rsp_wait   = $urandom_range(0, 2);
      end else begin
        rsp_wait--;
      end
    end
  end

  function automatic logic [70:0] mk(input logic li, input logic [7:0] lv,
                                     input logic ri, input logic [7:0] rv);
    return {7'd8, li, lv, ri, rv, 46'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic build_tree();
    for (int i = 0; i < 128; i++) tree[i] = '0;
    tree[8] = mk(1, 8'd6,  1, 8'd7);
    tree[7] = mk(0, 8'd74, 1, 8'd5);
    tree[6] = mk(1, 8'd3,  1, 8'd4);
    tree[5] = mk(0, 8'd71, 1, 8'd2);
    tree[4] = mk(0, 8'd70, 1, 8'd1);
    tree[3] = mk(1, 8'd0,  0, 8'd65);
    tree[2] = mk(0, 8'd72, 0, 8'd73);
    tree[1] = mk(0, 8'd68, 0, 8'd69);
    tree[0] = mk(0, 8'd67, 0, 8'd66);
  endtask

  // Code table by breadth-first search from the root: path bits MSB-first.
  task automatic build_codes();
    int qn[$]; int qp[$]; int ql[$];
    for (int i = 0; i < 256; i++) begin code_path[i] = 0; code_len[i] = 0; end
    qn.push_back(8); qp.push_back(0); ql.push_back(0);
    while (qn.size() > 0) begin
      int n, p, l;
      n = qn.pop_front(); p = qp.pop_front(); l = ql.pop_front();
      for (int b = 0; b < 2; b++) begin
        logic [8:0] c;
        c = (b == 1) ? tree[n][54:46] : tree[n][63:55];
        if (c[8]) begin
          qn.push_back(int'(c[7:0])); qp.push_back((p << 1) | b); ql.push_back(l + 1);
        end else begin
          code_path[c[7:0]] = (p << 1) | b;
          code_len[c[7:0]]  = l + 1;
        end
      end
    end
  endtask

  task automatic clear_stim();
    stim_bits.delete(); exp_chars.delete(); exp_fetch.delete(); exp_err = 1'b0;
  endtask

  task automatic add_char(input logic [7:0] c);
    exp_chars.push_back(c);
    for (int k = code_len[c] - 1; k >= 0; k--) stim_bits.push_back(code_path[c][k]);
  endtask

  // Expected node fetch order and error outcome from walking the tree array with the bit list.
  task automatic model_walk(input int n);
    int cur, got;
    logic [8:0] c;
    cur = 8; got = 0;
    if (n == 0) return;
    exp_fetch.push_back(7'(cur));
    foreach (stim_bits[i]) begin
      c = stim_bits[i] ? tree[cur][54:46] : tree[cur][63:55];
      if (c[8]) begin
        if (int'(c[7:0]) > 8) begin exp_err = 1'b1; break; end
        cur = int'(c[7:0]);
        exp_fetch.push_back(7'(cur));
      end else begin
        got++;
        if (got == n) break;
        cur = 8;
        exp_fetch.push_back(7'(cur));
      end
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    fetch_log.delete();
    @(negedge clk);
    max_index = 7'd8; num_chars = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_decode(input string tag, input int n, input int hold);
    bit finished;
    int hold_left, nf;
    finished = 0; hold_left = hold;
    do_start(16'(n));
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (char_valid && hold_left > 0) begin
        char_ready = 1'b0;
        bit_valid  = (stim_bits.size() > 0);
        bit_in     = (stim_bits.size() > 0) ? stim_bits[0] : 1'b0;
        #1;
        chk({tag, "_hold_valid"}, 32'(char_valid), 1);
        chk({tag, "_hold_char"}, 32'(char_out), 32'(exp_chars.size() > 0 ? exp_chars[0] : 8'd0));
        chk({tag, "_hold_bit_ready"}, 32'(bit_ready), 0);
        hold_left--;
        continue;
      end
      bit_valid  = (stim_bits.size() > 0) && ($urandom_range(0, 3) != 0);
      bit_in     = (stim_bits.size() > 0) ? stim_bits[0] : 1'b0;
      char_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bit_valid && bit_ready) void'(stim_bits.pop_front());
      if (char_valid && char_ready) begin
        if (exp_chars.size() == 0) chk({tag, "_extra_char"}, 1, 0);
        else chk({tag, "_char"}, 32'(char_out), 32'(exp_chars.pop_front()));
      end
      if (done || err) finished = 1;
    end
    @(negedge clk);
    bit_valid = 1'b0; char_ready = 1'b0;
    #1;
    chk({tag, "_timeout"}, 32'(finished), 1);
    chk({tag, "_done"}, 32'(done), 32'(!exp_err));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_chars_left"}, 32'(exp_chars.size()), 0);
    chk({tag, "_fetch_cnt"}, 32'(fetch_log.size()), 32'(exp_fetch.size()));
    nf = (fetch_log.size() < exp_fetch.size()) ? fetch_log.size() : exp_fetch.size();
    for (int i = 0; i < nf; i++) chk({tag, "_fetch_idx"}, 32'(fetch_log[i]), 32'(exp_fetch[i]));
  endtask

  initial begin
    bit found;
    int n;
    build_tree();
    build_codes();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_node_req", 32'(node_req), 0);
    chk("rst_node_index", 32'(node_index), 0);
    chk("rst_bit_ready", 32'(bit_ready), 0);
    chk("rst_char_valid", 32'(char_valid), 0);
    chk("rst_char_out", 32'(char_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    nrst = 1'b1;

    // 1: single 'J', fetches 8,7
    clear_stim(); add_char(8'd74); model_walk(1);
    chk("t1_fetch_model", 32'(exp_fetch.size()), 2);
    run_decode("t1", 1, 0);

    // 2: literal bitstream 0001 001 110 -> B, A, G
    clear_stim();
    stim_bits = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 0};
    exp_chars = '{8'd66, 8'd65, 8'd71};
    model_walk(3);
    run_decode("t2", 3, 0);

    // 3: 'A' held 5 cycles with the next char's bit on offer, then 'J'
    clear_stim(); add_char(8'd65); add_char(8'd74); model_walk(2);
    run_decode("t3", 2, 5);

    // 4: zero chars -> done the next cycle, no fetch
    clear_stim();
    do_start(16'd0);
    #1;
    chk("t4_done_next", 32'(done), 1);
    chk("t4_node_req", 32'(node_req), 0);
    repeat (3) @(negedge clk);
    chk("t4_no_fetch", 32'(fetch_log.size()), 0);

    // 5: corrupt node 7 right child -> error; then restart cleanly
    tree[7] = mk(0, 8'd74, 1, 8'd9);
    clear_stim();
    stim_bits = '{1, 1};
    model_walk(1);
    chk("t5_model_err", 32'(exp_err), 1);
    run_decode("t5", 1, 0);
    chk("t5_bit_consumed", 32'(stim_bits.size()), 0);
    build_tree();
    clear_stim(); add_char(8'd74); model_walk(1);
    run_decode("t5b", 1, 0);

    // 6: reset while fetching node 6
    clear_stim(); add_char(8'd66); model_walk(1);
    do_start(16'd1);
    found = 0;
    for (int cyc = 0; cyc < 200 && !found; cyc++) begin
      @(negedge clk);
      bit_valid = (stim_bits.size() > 0);
      bit_in    = (stim_bits.size() > 0) ? stim_bits[0] : 1'b0;
      #1;
      if (node_req && node_index == 7'd6) found = 1;
      else if (bit_valid && bit_ready) void'(stim_bits.pop_front());
    end
    chk("t6_reached_node6", 32'(found), 1);
    nrst = 1'b0;
    bit_valid = 1'b0;
    #1;
    chk("t6_node_req", 32'(node_req), 0);
    chk("t6_node_index", 32'(node_index), 0);
    chk("t6_bit_ready", 32'(bit_ready), 0);
    chk("t6_char_valid", 32'(char_valid), 0);
    chk("t6_char_out", 32'(char_out), 0);
    chk("t6_done", 32'(done), 0);
    chk("t6_err", 32'(err), 0);
    @(negedge clk);
    nrst = 1'b1;
    clear_stim(); add_char(8'd74); model_walk(1);
    run_decode("t6b", 1, 0);

    // Randomized messages over all ten symbols
    for (int r = 0; r < 6; r++) begin
      clear_stim();
      n = $urandom_range(1, 10);
      for (int k = 0; k < n; k++) add_char(8'(65 + $urandom_range(0, 9)));
      model_walk(n);
      run_decode("rnd", n, (r == 2) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
